// File: rtl/ahb_slave_if_multi.sv
// AHB slave front end for the APB bridge: region decode, PIPE_DEPTH-stage addr/data/write pipeline, two-cycle ERROR response.
// Latency: decode is combinational, Haddr2 lags by PIPE_DEPTH enabled cycles; Hreadyout follows bridge_rdy except in ERR1.
module ahb_slave_if_multi #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                NUM_SEL      = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'h8000_0000),
  parameter logic [ADDR_W-1:0] REGION_SIZE  = ADDR_W'(32'h0400_0000),
  parameter int                PIPE_DEPTH   = 2,
  parameter bit                HOLD_ON_WAIT = 1'b1
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [1:0]         Htrans,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  input  logic [DATA_W-1:0]  Prdata,
  input  logic               bridge_rdy,
  output logic [DATA_W-1:0]  Hrdata,
  output logic [1:0]         Hresp,
  output logic               Hreadyout,
  output logic               valid,
  output logic [NUM_SEL-1:0] tempselx,
  output logic [NUM_SEL-1:0] selx_d1,
  output logic [ADDR_W-1:0]  Haddr1,
  output logic [ADDR_W-1:0]  Haddr2,
  output logic [DATA_W-1:0]  Hwdata1,
  output logic [DATA_W-1:0]  Hwdata2,
  output logic               Hwritereg,
  output logic [7:0]         err_count
);

  // Extra headroom bits so BASE_ADDR + NUM_SEL*REGION_SIZE cannot wrap past 2^ADDR_W.
  localparam int             XW     = ADDR_W + 8;
  localparam int             RSH    = $clog2(REGION_SIZE);
  localparam logic [XW-1:0]  BASE_X = XW'(BASE_ADDR);
  localparam logic [XW-1:0]  SPAN_X = XW'(REGION_SIZE) * XW'(NUM_SEL);

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

  state_t            state, state_nxt;
  logic [XW-1:0]     addr_off;
  logic [XW-1:0]     region_idx;
  logic              mapped;
  logic              active;
  logic              err_start;
  logic              pipe_en;
  logic [ADDR_W-1:0] addr_q  [PIPE_DEPTH];
  logic [DATA_W-1:0] wdata_q [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] write_q;

  assign addr_off   = XW'(Haddr) - BASE_X;
  assign mapped     = (XW'(Haddr) >= BASE_X) && (addr_off < SPAN_X);
  assign region_idx = addr_off >> RSH;
  assign active     = Hreadyin & Htrans[1];
  assign valid      = active & mapped & (state != ST_ERR1);
  assign Hrdata     = Prdata;
  assign pipe_en    = HOLD_ON_WAIT ? Hreadyin : 1'b1;

  always_comb begin
    tempselx = '0;
    for (int i = 0; i < NUM_SEL; i++)
      tempselx[i] = mapped && (region_idx == XW'(i));
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        addr_q[k]  <= '0;
        wdata_q[k] <= '0;
      end
      write_q <= '0;
      selx_d1 <= '0;
    end else if (pipe_en) begin
      addr_q[0]  <= Haddr;
      wdata_q[0] <= Hwdata;
      write_q[0] <= Hwrite;
      selx_d1    <= tempselx;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        addr_q[k]  <= addr_q[k-1];
        wdata_q[k] <= wdata_q[k-1];
        write_q[k] <= write_q[k-1];
      end
    end
  end

  assign Haddr1    = addr_q[0];
  assign Haddr2    = addr_q[PIPE_DEPTH-1];
  assign Hwdata1   = wdata_q[0];
  assign Hwdata2   = wdata_q[PIPE_DEPTH-1];
  assign Hwritereg = write_q[PIPE_DEPTH-1];

  always_ff @(posedge Hclk) begin
    if (!Hresetn) state <= ST_OKAY;
    else          state <= state_nxt;
  end

  // ERR2 already returns Hreadyout=1, so a new unmapped transfer there starts a fresh error.
  always_comb begin
    state_nxt = state;
    Hresp     = 2'b00;
    Hreadyout = bridge_rdy;
    err_start = 1'b0;
    case (state)
      ST_OKAY: begin
        if (active && !mapped) begin
          state_nxt = ST_ERR1;
          err_start = 1'b1;
        end
      end
      ST_ERR1: begin
        Hresp     = 2'b01;
        Hreadyout = 1'b0;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        Hresp     = 2'b01;
        Hreadyout = 1'b1;
        if (active && !mapped) begin
          state_nxt = ST_ERR1;
          err_start = 1'b1;
        end else begin
          state_nxt = ST_OKAY;
        end
      end
      default: state_nxt = ST_OKAY;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn)                            err_count <= '0;
    else if (err_start && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

endmodule

// File: tb/tb_ahb_slave_if_multi.sv
// Drives a default instance and a NUM_SEL=4/PIPE_DEPTH=3/HOLD_ON_WAIT=0 instance from shared inputs,
// checking both against an address-map/capture-history model every cycle plus hand-computed literals.
module tb_ahb_slave_if_multi;

  logic        Hclk, Hresetn, Hwrite, Hreadyin, bridge_rdy;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata;

  logic [31:0] rd0, a1_0, a2_0, w1_0, w2_0, rd1, a1_1, a2_1, w1_1, w2_1;
  logic [1:0]  resp0, resp1;
  logic        ro0, v0, wr0, ro1, v1, wr1;
  logic [2:0]  ts0, sd0;
  logic [3:0]  ts1, sd1;
  logic [7:0]  ec0, ec1;

  ahb_slave_if_multi dut0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .bridge_rdy(bridge_rdy),
    .Hrdata(rd0), .Hresp(resp0), .Hreadyout(ro0), .valid(v0), .tempselx(ts0), .selx_d1(sd0),
    .Haddr1(a1_0), .Haddr2(a2_0), .Hwdata1(w1_0), .Hwdata2(w2_0), .Hwritereg(wr0), .err_count(ec0));

  ahb_slave_if_multi #(.NUM_SEL(4), .PIPE_DEPTH(3), .HOLD_ON_WAIT(1'b0)) dut1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .bridge_rdy(bridge_rdy),
    .Hrdata(rd1), .Hresp(resp1), .Hreadyout(ro1), .valid(v1), .tempselx(ts1), .selx_d1(sd1),
    .Haddr1(a1_1), .Haddr2(a2_1), .Hwdata1(w1_1), .Hwdata2(w2_1), .Hwritereg(wr1), .err_count(ec1));

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int CAPN = 8192;
  function automatic int nsel_of(input int d);  return (d == 0) ? 3 : 4; endfunction
  function automatic int depth_of(input int d); return (d == 0) ? 2 : 3; endfunction
  function automatic bit hold_of(input int d);  return (d == 0);         endfunction

  // Region one-hot from plain 64-bit arithmetic; zero when outside the window.
  function automatic logic [3:0] dec(input logic [31:0] a, input int nsel);
    longint unsigned aa, lo, hi;
    aa = 64'(a);
    lo = 64'h8000_0000;
    hi = lo + longint'(nsel) * 64'h0400_0000;
    if (aa >= lo && aa < hi) return 4'(64'd1 << ((aa - lo) / 64'h0400_0000));
    return 4'd0;
  endfunction

  logic [31:0] cap_a  [2][CAPN];
  logic [31:0] cap_w  [2][CAPN];
  logic        cap_wr [2][CAPN];
  logic [3:0]  cap_s  [2][CAPN];
  int          ncap   [2];
  int          err_ph [2];   // 0 none, 1 first ERROR cycle, 2 second ERROR cycle
  int          ecnt   [2];

  always @(posedge Hclk) begin
    for (int d = 0; d < 2; d++) begin
      if (!Hresetn) begin
        ncap[d] = 0; err_ph[d] = 0; ecnt[d] = 0;
      end else begin
        logic [3:0] s;
        s = dec(Haddr, nsel_of(d));
        if (err_ph[d] == 1) err_ph[d] = 2;
        else if (Hreadyin && Htrans[1] && s == 4'd0) begin
          err_ph[d] = 1;
          if (ecnt[d] < 255) ecnt[d]++;
        end else err_ph[d] = 0;
        if ((!hold_of(d) || Hreadyin) && ncap[d] < CAPN) begin
          cap_a[d][ncap[d]] = Haddr;  cap_w[d][ncap[d]] = Hwdata;
          cap_wr[d][ncap[d]] = Hwrite; cap_s[d][ncap[d]] = s;
          ncap[d]++;
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input logic [31:0] rd, a1, a2, w1, w2, input logic [1:0] resp,
                         input logic ro, v, wr, input logic [3:0] ts, sd, input logic [7:0] ec);
    int n, dp;
    logic [3:0] s;
    n  = ncap[d];
    dp = depth_of(d);
    s  = dec(Haddr, nsel_of(d));
    chk($sformatf("d%0d.Hrdata", d), 64'(rd), 64'(Prdata));
    chk($sformatf("d%0d.tempselx", d), 64'(ts), 64'(s));
    chk($sformatf("d%0d.valid", d), 64'(v), 64'(Hreadyin && Htrans[1] && s != 0 && err_ph[d] != 1));
    chk($sformatf("d%0d.Hresp", d), 64'(resp), (err_ph[d] != 0) ? 64'd1 : 64'd0);
    chk($sformatf("d%0d.Hreadyout", d), 64'(ro),
        (err_ph[d] == 1) ? 64'd0 : (err_ph[d] == 2) ? 64'd1 : 64'(bridge_rdy));
    chk($sformatf("d%0d.err_count", d), 64'(ec), 64'(ecnt[d]));
    chk($sformatf("d%0d.Haddr1", d), 64'(a1), (n >= 1) ? 64'(cap_a[d][n-1]) : 64'd0);
    chk($sformatf("d%0d.Hwdata1", d), 64'(w1), (n >= 1) ? 64'(cap_w[d][n-1]) : 64'd0);
    chk($sformatf("d%0d.selx_d1", d), 64'(sd), (n >= 1) ? 64'(cap_s[d][n-1]) : 64'd0);
    chk($sformatf("d%0d.Haddr2", d), 64'(a2), (n >= dp) ? 64'(cap_a[d][n-dp]) : 64'd0);
    chk($sformatf("d%0d.Hwdata2", d), 64'(w2), (n >= dp) ? 64'(cap_w[d][n-dp]) : 64'd0);
    chk($sformatf("d%0d.Hwritereg", d), 64'(wr), (n >= dp) ? 64'(cap_wr[d][n-dp]) : 64'd0);
  endtask

  always @(negedge Hclk) begin
    if (chk_en) begin
      cmp_dut(0, rd0, a1_0, a2_0, w1_0, w2_0, resp0, ro0, v0, wr0, {1'b0, ts0}, {1'b0, sd0}, ec0);
      cmp_dut(1, rd1, a1_1, a2_1, w1_1, w2_1, resp1, ro1, v1, wr1, ts1, sd1, ec1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge Hclk);
    #2;
  endtask

  logic [31:0] bnd [7];

  initial begin
    bnd = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8BFF_FFFF, 32'h8C00_0000,
            32'h8FFF_FFFF, 32'h9000_0000, 32'hFFFF_FFFF};
    Hresetn = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b1; bridge_rdy = 1'b1; Htrans = 2'b00;
    Haddr = 32'h0; Hwdata = 32'h0; Prdata = 32'h0;

    // Reset state
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst.Haddr1", 64'(a1_0), 64'd0);
    chk("rst.Haddr2", 64'(a2_0), 64'd0);
    chk("rst.Hwdata2", 64'(w2_0), 64'd0);
    chk("rst.Hwritereg", 64'(wr0), 64'd0);
    chk("rst.err_count", 64'(ec0), 64'd0);
    chk("rst.Hresp", 64'(resp0), 64'd0);

    // Mapped write into region 1
    Hresetn = 1'b1; Haddr = 32'h8400_0010; Htrans = 2'b10; Hwrite = 1'b1; Hwdata = 32'hCAFE_0001;
    #1;
    chk("wr.valid", 64'(v0), 64'd1);
    chk("wr.tempselx", 64'(ts0), 64'h2);
    cyc();
    Haddr = 32'h8000_0000; Htrans = 2'b00; Hwrite = 1'b0; Hwdata = 32'h0;
    #1;
    chk("wr.Haddr1", 64'(a1_0), 64'h8400_0010);
    chk("wr.selx_d1", 64'(sd0), 64'h2);
    cyc(); #1;
    chk("wr.Haddr2", 64'(a2_0), 64'h8400_0010);
    chk("wr.Hwritereg", 64'(wr0), 64'd1);
    chk("wr.Hwdata2", 64'(w2_0), 64'hCAFE_0001);
    cyc(); #1;
    chk("wr.d1.Haddr2", 64'(a2_1), 64'h8400_0010);

    // Window edges, including no wrap at the top of the address space
    Haddr = 32'h8BFF_FFFC; #1; chk("bnd.top3", 64'(ts0), 64'h4);
    Haddr = 32'h8C00_0000; #1; chk("bnd.past3", 64'(ts0), 64'h0);
    Haddr = 32'h7FFF_FFFC; #1; chk("bnd.below", 64'(ts1), 64'h0);
    Haddr = 32'hFFFF_FFFF; #1; chk("bnd.wrap", 64'(ts1), 64'h0);

    // Unmapped NONSEQ -> two-cycle ERROR
    cyc();
    Haddr = 32'h9000_0000; Htrans = 2'b10; #1;
    chk("err.valid", 64'(v0), 64'd0);
    cyc(); Htrans = 2'b00; #1;
    chk("err1.Hresp", 64'(resp0), 64'd1);
    chk("err1.Hreadyout", 64'(ro0), 64'd0);
    cyc(); #1;
    chk("err2.Hresp", 64'(resp0), 64'd1);
    chk("err2.Hreadyout", 64'(ro0), 64'd1);
    cyc(); #1;
    chk("err3.Hresp", 64'(resp0), 64'd0);
    chk("err.err_count", 64'(ec0), 64'd1);
    chk("err.d1.err_count", 64'(ec1), 64'd1);

    // Wait-state hold vs. free-running pipeline
    Haddr = 32'h8000_0100; Hreadyin = 1'b1;
    cyc(); cyc();
    Hreadyin = 1'b0; Htrans = 2'b10;
    Haddr = 32'h8000_0200; cyc();
    Haddr = 32'h8000_0300; cyc();
    Haddr = 32'h8000_0400; cyc();
    #1;
    chk("hold.d0.Haddr1", 64'(a1_0), 64'h8000_0100);
    chk("hold.d0.Haddr2", 64'(a2_0), 64'h8000_0100);
    chk("hold.d1.Haddr1", 64'(a1_1), 64'h8000_0400);
    chk("hold.d1.Haddr2", 64'(a2_1), 64'h8000_0200);

    // Reset during ERR1
    Hreadyin = 1'b1; Haddr = 32'h9000_0000; Htrans = 2'b10;
    cyc();
    Hresetn = 1'b0; Htrans = 2'b00; #1;
    chk("rerr.Hresp_pre", 64'(resp0), 64'd1);
    cyc(); #1;
    chk("rerr.Hresp", 64'(resp0), 64'd0);
    chk("rerr.Hreadyout", 64'(ro0), 64'd1);
    chk("rerr.err_count", 64'(ec0), 64'd0);
    Hresetn = 1'b1;

    // 260 separate unmapped transfers -> saturation
    for (int i = 0; i < 260; i++) begin
      Haddr = 32'h9000_0000; Htrans = 2'b10; cyc();
      Htrans = 2'b00; cyc(); cyc();
    end
    #1;
    chk("sat.d0.err_count", 64'(ec0), 64'hFF);
    chk("sat.d1.err_count", 64'(ec1), 64'hFF);

    // Four-region, three-stage instance
    Haddr = 32'h8C00_0000; #1;
    chk("p4.d1.tempselx", 64'(ts1), 64'h8);
    chk("p4.d0.tempselx", 64'(ts0), 64'h0);
    cyc(); cyc(); #1;
    chk("p4.d1.Haddr2_2clk", 64'(a2_1), 64'h9000_0000);
    cyc(); #1;
    chk("p4.d1.Haddr2_3clk", 64'(a2_1), 64'h8C00_0000);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      Hresetn    = ($urandom_range(0, 63) != 0);
      Htrans     = 2'($urandom_range(0, 3));
      Hreadyin   = ($urandom_range(0, 3) != 0);
      bridge_rdy = 1'($urandom_range(0, 1));
      Hwrite     = 1'($urandom_range(0, 1));
      Hwdata     = $urandom;
      Prdata     = $urandom;
      case ($urandom_range(0, 2))
        0:       Haddr = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
        1:       Haddr = $urandom;
        default: Haddr = bnd[$urandom_range(0, 6)];
      endcase
    end
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
